integrator_comb_decim: RTL and testbench
========================================

// Module: integrator_comb_decim
// PURPOSE
//  Decimating comb (differentiator) stage that pairs with the Integrator block.
//  Takes the integrator's wrapping running sum and keeps every R-th valid sample.
//  Outputs the difference between the kept sample and the one kept M decimated
//  samples earlier.
//  Integrator + this block together form a single-stage CIC decimator.
// PARAMETERS
//  W  10  sample width, signed two's complement, in and out
//  R   4  decimation ratio, 1..16
//  M   1  differential delay in decimated samples, 1..4
// PORTS
//  system1000       in   1  clock; all logic on rising edge
//  system1000_rstn  in   1  reset; synchronous, active-low
//  clr              in   1  synchronous soft clear, active-high
//  in_valid         in   1  in_data valid this cycle
//  in_data          in   W  signed integrator output (wrapping sum)
//  out_valid        out  1  one-cycle pulse: out_data is new
//  out_data         out  W  signed comb output
//  phase            out  4  decimation counter value, debug
// BEHAVIOUR
//  Reset, when system1000_rstn=0 at an edge:
//   - out_valid=0, out_data=0, phase=0
//   - all M delay registers = 0
//   - applies mid-operation; any partial decimation window is discarded
//  clr=1 at an edge:
//   - same effect as reset
//   - wins over a simultaneous in_valid; that sample is dropped
//  Decimation counter (phase):
//   - advances only on edges with in_valid=1; holds through gaps
//   - counts 0..R-1, then wraps to 0
//   - a sample is "taken" when in_valid=1 and phase=R-1
//   - the first sample taken after reset/clr is therefore the R-th valid input
//   - R=1: every valid input is taken; phase stays 0
//  On a take edge:
//   - out_data <= (in_data - dly[M-1]) mod 2^W
//   - subtraction is done at W bits and wraps; no saturation
//   - wrap is required for correct CIC behaviour
//   - dly shifts: dly[0] <= in_data, dly[k] <= dly[k-1]
//   - out_valid <= 1 for exactly one cycle
//  On non-take edges:
//   - out_valid <= 0; out_data, dly hold
//  Latency: out_valid rises the edge after the take cycle (1 cycle).
//  No priming suppression: outputs are valid from the first take, because the
//   integrator also resets to 0 and so the zero-filled delay line is exact.
//  Throughput: one take per R valid inputs. There is no backpressure; the
//   consumer must accept out_valid pulses unconditionally.
// TESTING (W=10, R=4, M=1 unless stated)
//  1. Ramp: in_data 3,6,9,...,36, in_valid=1 continuously
//     -> out_valid pulses after the 4th, 8th and 12th inputs
//     -> out_data 12,12,12
//  2. Wrap: taken samples 500 then -500 (a sum of 524 wrapped)
//     -> out_data 500, then 24 ((-1000) mod 1024)
//  3. Gaps: same data as test 1, with in_valid=0 on alternate cycles
//     -> identical out_data; pulses spaced 8 cycles apart; phase holds through gaps
//  4. Reset mid-window: after 2 valid inputs, rstn=0 for 1 cycle
//     -> next edge gives out_valid=0, phase=0
//     -> the next 4 inputs 5,5,5,7 give out_data=7
//  5. clr together with in_valid at phase=3
//     -> no out_valid; phase=0; dly=0
//  6. M=2, R=1: in_data 1,2,4,8
//     -> out_data 1,2,3,6

Source files
------------

// File: rtl/integrator_comb_decim.sv
// Decimating comb stage for a single-stage CIC: keeps every R-th valid sample
// of a wrapping integrator sum and outputs its difference to the one M takes earlier.
module integrator_comb_decim #(
  parameter int W = 10,
  parameter int R = 4,
  parameter int M = 1
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic                clr,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  output logic signed [W-1:0] out_data,
  output logic [3:0]          phase
);

  localparam logic [3:0] PHASE_LAST = 4'(R - 1);

  logic signed [W-1:0] dly [M];
  logic                take;

  assign take = in_valid && (phase == PHASE_LAST);

  // The zero-filled delay line matches the integrator's reset state, so no
  // priming suppression is needed after reset or clear.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn || clr) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      phase     <= '0;
      for (int k = 0; k < M; k++) dly[k] <= '0;
    end else begin
      out_valid <= take;
      if (in_valid) phase <= (phase == PHASE_LAST) ? 4'd0 : phase + 4'd1;
      if (take) begin
        out_data <= in_data - dly[M-1];
        dly[0]   <= in_data;
        for (int k = 1; k < M; k++) dly[k] <= dly[k-1];
      end
    end
  end

endmodule

// File: tb/tb_integrator_comb_decim.sv
// Directed bench for integrator_comb_decim: R=4/M=1 instance plus an R=1/M=2 instance.
module tb_integrator_comb_decim;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              clr0 = 1'b0, clr1 = 1'b0;
  logic              iv0 = 1'b0, iv1 = 1'b0;
  logic signed [9:0] id0 = '0, id1 = '0;
  logic              ov0, ov1;
  logic signed [9:0] od0, od1;
  logic [3:0]        ph0, ph1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  integrator_comb_decim #(.W(10), .R(4), .M(1)) dut0 (
    .system1000(clk), .system1000_rstn(rstn), .clr(clr0),
    .in_valid(iv0), .in_data(id0),
    .out_valid(ov0), .out_data(od0), .phase(ph0)
  );

  integrator_comb_decim #(.W(10), .R(1), .M(2)) dut1 (
    .system1000(clk), .system1000_rstn(rstn), .clr(clr1),
    .in_valid(iv1), .in_data(id1),
    .out_valid(ov1), .out_data(od1), .phase(ph1)
  );

  task automatic step0(input logic v, input logic signed [9:0] d);
    iv0 = v;
    id0 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ov0 !== 1'b0 || od0 !== 10'sd0 || ph0 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: ov=%b od=%0d ph=%0d required 0 0 0", ov0, od0, ph0);
    end
    rstn = 1'b1;
  endtask

  task automatic test_ramp();
    logic signed [9:0] d;
    for (int k = 1; k <= 12; k++) begin
      d = 10'(3 * k);
      step0(1'b1, d);
      n_cmp++;
      if (ph0 !== 4'(k % 4) || ov0 !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL ramp k=%0d: ph=%0d ov=%b required ph=%0d ov=%b",
                 k, ph0, ov0, k % 4, (k % 4 == 0));
      end
      if (k % 4 == 0) begin
        n_cmp++;
        if (od0 !== 10'sd12) begin
          n_fail++;
          $display("FAIL ramp_data k=%0d: od=%0d required 12", k, od0);
        end
      end
    end
  endtask

  task automatic test_wrap();
    clr0 = 1'b1;
    step0(1'b0, 10'sd0);
    clr0 = 1'b0;
    repeat (3) step0(1'b1, 10'sd0);
    step0(1'b1, 10'sd500);
    n_cmp++;
    if (ov0 !== 1'b1 || od0 !== 10'sd500) begin
      n_fail++;
      $display("FAIL wrap_first: ov=%b od=%0d required 1 500", ov0, od0);
    end
    repeat (3) step0(1'b1, 10'sd0);
    step0(1'b1, -10'sd500);
    n_cmp++;
    if (ov0 !== 1'b1 || od0 !== 10'sd24) begin
      n_fail++;
      $display("FAIL wrap_second: ov=%b od=%0d required 1 24", ov0, od0);
    end
  endtask

  task automatic test_gaps();
    int last_take;
    int cyc;
    logic [3:0] ph_before;
    logic signed [9:0] od_before;
    clr0 = 1'b1;
    step0(1'b0, 10'sd0);
    clr0 = 1'b0;
    last_take = -1;
    cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      step0(1'b1, 10'(3 * k));
      if (k % 4 == 0) begin
        n_cmp++;
        if (ov0 !== 1'b1 || od0 !== 10'sd12) begin
          n_fail++;
          $display("FAIL gaps_take k=%0d: ov=%b od=%0d required 1 12", k, ov0, od0);
        end
        if (last_take >= 0) begin
          n_cmp++;
          if (cyc - last_take !== 8) begin
            n_fail++;
            $display("FAIL gaps_spacing: got %0d cycles required 8", cyc - last_take);
          end
        end
        last_take = cyc;
      end
      cyc++;
      ph_before = ph0;
      od_before = od0;
      step0(1'b0, 10'sd99);
      cyc++;
      n_cmp++;
      if (ph0 !== ph_before || ov0 !== 1'b0 || od0 !== od_before) begin
        n_fail++;
        $display("FAIL gaps_hold k=%0d: ph=%0d ov=%b od=%0d required %0d 0 %0d",
                 k, ph0, ov0, od0, ph_before, od_before);
      end
    end
  endtask

  task automatic test_reset_mid();
    step0(1'b1, 10'sd9);
    step0(1'b1, 10'sd9);
    rstn = 1'b0;
    step0(1'b0, 10'sd0);
    rstn = 1'b1;
    n_cmp++;
    if (ov0 !== 1'b0 || ph0 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: ov=%b ph=%0d required 0 0", ov0, ph0);
    end
    step0(1'b1, 10'sd5);
    step0(1'b1, 10'sd5);
    step0(1'b1, 10'sd5);
    n_cmp++;
    if (ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_early: ov=%b required 0", ov0);
    end
    step0(1'b1, 10'sd7);
    n_cmp++;
    if (ov0 !== 1'b1 || od0 !== 10'sd7) begin
      n_fail++;
      $display("FAIL reset_mid_data: ov=%b od=%0d required 1 7", ov0, od0);
    end
  endtask

  task automatic test_clr();
    repeat (3) step0(1'b1, 10'sd20);
    n_cmp++;
    if (ph0 !== 4'd3) begin
      n_fail++;
      $display("FAIL clr_setup: ph=%0d required 3", ph0);
    end
    clr0 = 1'b1;
    step0(1'b1, 10'sd100);
    clr0 = 1'b0;
    n_cmp++;
    if (ov0 !== 1'b0 || ph0 !== 4'd0 || od0 !== 10'sd0) begin
      n_fail++;
      $display("FAIL clr: ov=%b ph=%0d od=%0d required 0 0 0", ov0, ph0, od0);
    end
    repeat (3) step0(1'b1, 10'sd0);
    step0(1'b1, 10'sd50);
    n_cmp++;
    if (ov0 !== 1'b1 || od0 !== 10'sd50) begin
      n_fail++;
      $display("FAIL clr_dly: ov=%b od=%0d required 1 50", ov0, od0);
    end
  endtask

  task automatic test_m2_r1();
    logic signed [9:0] din [4];
    logic signed [9:0] exp [4];
    din = '{10'sd1, 10'sd2, 10'sd4, 10'sd8};
    exp = '{10'sd1, 10'sd2, 10'sd3, 10'sd6};
    rstn = 1'b0;
    step0(1'b0, 10'sd0);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iv1 = 1'b1;
      id1 = din[k];
      @(posedge clk);
      #1;
      n_cmp++;
      if (ov1 !== 1'b1 || od1 !== exp[k] || ph1 !== 4'd0) begin
        n_fail++;
        $display("FAIL m2_r1 k=%0d: ov=%b od=%0d ph=%0d required 1 %0d 0",
                 k, ov1, od1, ph1, exp[k]);
      end
    end
    iv1 = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (ov1 !== 1'b0 || od1 !== 10'sd6) begin
      n_fail++;
      $display("FAIL m2_r1_idle: ov=%b od=%0d required 0 6", ov1, od1);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_wrap();
    test_gaps();
    test_reset_mid();
    test_clr();
    test_m2_r1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
